tile_colour_writeback: RTL and testbench

- Downstream neighbour of the per-tile depth stage.
- Holds the 32x32 ARGB colour tile. Shaded pixels that passed the depth test are written into it.
- On flush, converts the tile to RGB565, packs two pixels per 32-bit word and streams the tile to the VRAM framebuffer over a write/wait interface.
- Also performs a background-colour clear of the tile between tiles.

---
 rtl/tile_colour_writeback_pkg.sv | 27 ++
 rtl/tile_colour_writeback_if.sv | 14 +
 rtl/tile_colour_writeback_ram.sv | 44 ++++
 rtl/tile_colour_writeback.sv | 183 ++++++++++++++++++
 tb/tb_tile_colour_writeback.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_colour_writeback_pkg.sv
// Shared definitions for the tile colour writeback block: tile geometry,
// VRAM word-address width, controller state encoding and the colour
// conversion used when packing pixels for the framebuffer.
package tile_colour_writeback_pkg;

  localparam int TILE_DIM = 32;
  localparam int PIX_AW   = $clog2(TILE_DIM * TILE_DIM);  // 10-bit {row, col}
  localparam int BANK_AW  = PIX_AW - 1;                   // 512 entries per bank
  localparam int VRAM_AW  = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SETUP = 3'd2,
    RD    = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } wb_state_e;

  // Truncating ARGB8888 -> RGB565; alpha and low colour bits are dropped.
  function automatic logic [15:0] argb_to_rgb565(input logic [31:0] p);
    return 16'(((p >> 5'd8) & 32'h0000_F800) |
               ((p >> 5'd5) & 32'h0000_07E0) |
               ((p >> 5'd3) & 32'h0000_001F));
  endfunction

endpackage

// File: rtl/tile_colour_writeback_if.sv
// VRAM write/wait bus between the writeback block and the framebuffer.
// A beat transfers on any cycle with vram_wr high and vram_wait low.
interface tile_colour_writeback_if;
  import tile_colour_writeback_pkg::*;

  logic               vram_wr;
  logic [VRAM_AW-1:0] vram_addr;
  logic [31:0]        vram_din;
  logic               vram_wait;

  modport master (output vram_wr, vram_addr, vram_din, input vram_wait);
  modport slave  (input vram_wr, vram_addr, vram_din, output vram_wait);

endinterface

// File: rtl/tile_colour_writeback_ram.sv
// Dual-bank 512x32 colour store. Even columns live in one bank and odd
// columns in the other, so a single read index yields one packed pair.
// One write port (either or both banks) and a registered 1-cycle read.
module tile_colour_ram
  import tile_colour_writeback_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               we_even,
  input  logic               we_odd,
  input  logic [BANK_AW-1:0] wr_idx,
  input  logic [31:0]        wr_data,
  input  logic               rd_en,
  input  logic [BANK_AW-1:0] rd_idx,
  output logic [31:0]        rd_even,
  output logic [31:0]        rd_odd
);

  logic [31:0] bank_even [0:(1 << BANK_AW) - 1];
  logic [31:0] bank_odd  [0:(1 << BANK_AW) - 1];

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we_even) begin
      bank_even[wr_idx] <= wr_data;
    end
    if (we_odd) begin
      bank_odd[wr_idx] <= wr_data;
    end
  end

  // Read data registers: hold between reads so the bus data stays stable
  // while the VRAM stalls, and clear on reset so the bus idles at zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_even <= 32'h0000_0000;
      rd_odd  <= 32'h0000_0000;
    end else if (rd_en) begin
      rd_even <= bank_even[rd_idx];
      rd_odd  <= bank_odd[rd_idx];
    end
  end

endmodule

// File: rtl/tile_colour_writeback.sv
// Tile colour writeback: accepts depth-qualified shaded pixels into a 32x32
// ARGB tile, clears the tile to a background colour on request, and on flush
// streams the tile as RGB565 pairs to the VRAM framebuffer.
module tile_colour_writeback
  import tile_colour_writeback_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pix_write,
  input  logic [PIX_AW-1:0]  pix_addr,
  input  logic [31:0]        pix_argb,
  input  logic               clear_tile,
  input  logic [31:0]        bg_argb,
  input  logic               flush,
  input  logic [5:0]         tile_x,
  input  logic [4:0]         tile_y,
  input  logic [VRAM_AW-1:0] fb_base,
  input  logic [11:0]        fb_stride,
  output logic               busy,
  output logic               clear_done,
  output logic               flush_done,
  tile_colour_writeback_if.master vram
);

  wb_state_e          state_r;
  logic [BANK_AW-1:0] cnt_r;        // clear index, or word counter w during flush
  logic [31:0]        bg_r;
  logic [5:0]         tile_x_r;
  logic [4:0]         tile_y_r;
  logic [VRAM_AW-1:0] base_r;
  logic [11:0]        stride_r;
  logic [VRAM_AW-1:0] row_addr_r;   // framebuffer address of the current tile row
  logic               busy_r;
  logic               clear_done_r;
  logic               flush_done_r;
  logic               vram_wr_r;
  logic [VRAM_AW-1:0] vram_addr_r;

  logic               we_even_s;
  logic               we_odd_s;
  logic [BANK_AW-1:0] wr_idx_s;
  logic [31:0]        wr_data_s;
  logic               rd_en_s;
  logic [31:0]        rd_even_s;
  logic [31:0]        rd_odd_s;
  logic [VRAM_AW-1:0] tile_off_s;

  tile_colour_ram u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we_even (we_even_s),
    .we_odd  (we_odd_s),
    .wr_idx  (wr_idx_s),
    .wr_data (wr_data_s),
    .rd_en   (rd_en_s),
    .rd_idx  (cnt_r),
    .rd_even (rd_even_s),
    .rd_odd  (rd_odd_s)
  );

  // Write port steering: shaded pixels only in IDLE, both banks during clear.
  always_comb begin
    we_even_s = 1'b0;
    we_odd_s  = 1'b0;
    wr_idx_s  = pix_addr[PIX_AW-1:1];
    wr_data_s = pix_argb;
    case (state_r)
      IDLE: begin
        we_even_s = pix_write & ~pix_addr[0];
        we_odd_s  = pix_write &  pix_addr[0];
      end
      CLEAR: begin
        we_even_s = 1'b1;
        we_odd_s  = 1'b1;
        wr_idx_s  = cnt_r;
        wr_data_s = bg_r;
      end
      default: begin
        we_even_s = 1'b0;
        we_odd_s  = 1'b0;
      end
    endcase
  end

  assign rd_en_s = (state_r == RD);

  // Tile origin offset in words: 32 lines per tile row, 16 words per tile column.
  assign tile_off_s = VRAM_AW'({tile_y_r, 5'b00000}) * VRAM_AW'(stride_r)
                    + VRAM_AW'({tile_x_r, 4'b0000});

  // Controller FSM with all externally visible outputs registered.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= {BANK_AW{1'b0}};
      bg_r         <= 32'h0000_0000;
      tile_x_r     <= 6'd0;
      tile_y_r     <= 5'd0;
      base_r       <= {VRAM_AW{1'b0}};
      stride_r     <= 12'd0;
      row_addr_r   <= {VRAM_AW{1'b0}};
      busy_r       <= 1'b0;
      clear_done_r <= 1'b0;
      flush_done_r <= 1'b0;
      vram_wr_r    <= 1'b0;
      vram_addr_r  <= {VRAM_AW{1'b0}};
    end else begin
      clear_done_r <= 1'b0;
      flush_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (flush) begin
            // flush wins; a coincident clear request is dropped
            state_r  <= SETUP;
            busy_r   <= 1'b1;
            tile_x_r <= tile_x;
            tile_y_r <= tile_y;
            base_r   <= fb_base;
            stride_r <= fb_stride;
          end else if (clear_tile) begin
            state_r <= CLEAR;
            busy_r  <= 1'b1;
            bg_r    <= bg_argb;
            cnt_r   <= {BANK_AW{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          cnt_r <= cnt_r + 9'd1;
          if (cnt_r == 9'd511) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b1;
          end
        end
        SETUP: begin
          row_addr_r <= base_r + tile_off_s;
          cnt_r      <= {BANK_AW{1'b0}};
          state_r    <= RD;
        end
        RD: begin
          vram_wr_r   <= 1'b1;
          vram_addr_r <= row_addr_r + VRAM_AW'(cnt_r[3:0]);
          state_r     <= WR;
        end
        WR: begin
          if (!vram.vram_wait) begin
            vram_wr_r <= 1'b0;
            cnt_r     <= cnt_r + 9'd1;
            if (cnt_r[3:0] == 4'hF) begin
              row_addr_r <= row_addr_r + VRAM_AW'(stride_r);
            end
            if (cnt_r == 9'd511) begin
              state_r      <= DONE;
              flush_done_r <= 1'b1;
            end else begin
              state_r <= RD;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          vram_wr_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_r;
  assign clear_done     = clear_done_r;
  assign flush_done     = flush_done_r;
  assign vram.vram_wr   = vram_wr_r;
  assign vram.vram_addr = vram_addr_r;
  // Data is a pure repacking of the RAM read registers, which only change in RD.
  assign vram.vram_din  = {argb_to_rgb565(rd_odd_s), argb_to_rgb565(rd_even_s)};

endmodule

// File: tb/tb_tile_colour_writeback.sv
// Self-checking bench for tile_colour_writeback. A tile array model plus
// row/column address arithmetic predicts every VRAM beat.
module tb_tile_colour_writeback;
  import tile_colour_writeback_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        pix_write;
  logic [9:0]  pix_addr;
  logic [31:0] pix_argb;
  logic        clear_tile;
  logic [31:0] bg_argb;
  logic        flush;
  logic [5:0]  tile_x;
  logic [4:0]  tile_y;
  logic [23:0] fb_base;
  logic [11:0] fb_stride;
  logic        busy;
  logic        clear_done;
  logic        flush_done;

  tile_colour_writeback_if vif ();

  tile_colour_writeback dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pix_write  (pix_write),
    .pix_addr   (pix_addr),
    .pix_argb   (pix_argb),
    .clear_tile (clear_tile),
    .bg_argb    (bg_argb),
    .flush      (flush),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .fb_base    (fb_base),
    .fb_stride  (fb_stride),
    .busy       (busy),
    .clear_done (clear_done),
    .flush_done (flush_done),
    .vram       (vif)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [0:1023];
  logic [23:0] first_addr;
  logic [31:0] first_data;
  int          last_stalls;
  int          last_done;

  typedef struct {
    logic [31:0] pix0;
    logic [31:0] pix1;
    logic [23:0] base;
    logic [11:0] stride;
    logic [5:0]  tx;
    logic [4:0]  ty;
    int          wait_mode;
    logic [23:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_565(input logic [31:0] p);
    logic [15:0] r;
    r = {p[23:19], p[15:10], p[7:3]};
    return r;
  endfunction

  // Word k covers tile line k/16, word k%16 of that line.
  function automatic logic [23:0] ref_addr(input logic [23:0] base, input logic [11:0] stride,
                                           input logic [5:0] tx, input logic [4:0] ty, input int k);
    longint a;
    a = longint'(base) + longint'(int'(ty) * 32 + k / 16) * longint'(stride)
      + longint'(tx) * 16 + longint'(k % 16);
    return a[23:0];
  endfunction

  function automatic logic [31:0] ref_data(input int k);
    int row;
    int col;
    row = k / 16;
    col = (k % 16) * 2;
    return {ref_565(model[row * 32 + col + 1]), ref_565(model[row * 32 + col])};
  endfunction

  task automatic write_pix(input int a, input logic [31:0] d);
    pix_write = 1'b1;
    pix_addr  = 10'(a);
    pix_argb  = d;
    model[a]  = d;
    @(negedge clock);
    pix_write = 1'b0;
  endtask

  task automatic run_clear(input logic [31:0] bg);
    int done_k;
    done_k     = -1;
    clear_tile = 1'b1;
    bg_argb    = bg;
    for (int k = 1; k <= 520; k++) begin
      @(negedge clock);
      if (k == 1) begin
        clear_tile = 1'b0;
        bg_argb    = $urandom;
        check("clear_busy_start", busy, 1'b1);
      end
      if (k == 513) check("clear_busy_end", busy, 1'b0);
      if (clear_done && done_k < 0) done_k = k;
    end
    check("clear_done_cycle", done_k, 513);
    for (int i = 0; i < 1024; i++) model[i] = bg;
  endtask

  // Starts a flush at the current negedge (cycle T) and follows it to the end.
  task automatic run_flush(input logic [23:0] base, input logic [11:0] stride,
                           input logic [5:0] tx, input logic [4:0] ty, input int wait_mode,
                           input bit busy_noise, input bit with_clear, input int abort_at);
    int   beat;
    int   stalls;
    int   done_k;
    int   stall_cnt;
    bit   new_beat;
    bit   seen_cd;
    bit   aborted;
    bit   w;
    bit   bad_done;
    bit   bad_wr;
    beat = 0; stalls = 0; done_k = -1; stall_cnt = 0;
    new_beat = 1'b1; seen_cd = 1'b0; aborted = 1'b0;
    flush      = 1'b1;
    clear_tile = with_clear;
    bg_argb    = $urandom;
    fb_base    = base;
    fb_stride  = stride;
    tile_x     = tx;
    tile_y     = ty;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clock);
      flush         = 1'b0;
      clear_tile    = 1'b0;
      pix_write     = 1'b0;
      vif.vram_wait = 1'b0;
      if (k == 1) begin
        fb_base = 24'($urandom); fb_stride = 12'($urandom);
        tile_x  = 6'($urandom);  tile_y    = 5'($urandom);
      end
      if (clear_done) seen_cd = 1'b1;
      if (busy_noise && !flush_done) begin
        pix_write  = 1'($urandom_range(0, 1));
        pix_addr   = 10'($urandom);
        pix_argb   = $urandom;
        flush      = 1'($urandom_range(0, 1));
        clear_tile = 1'($urandom_range(0, 1));
      end
      if (vif.vram_wr) begin
        if (beat >= 512) begin
          check("beat_index", beat, 511);
        end else begin
          if (new_beat) begin
            check("beat_cycle", k, 3 + 2 * beat + stalls);
            new_beat = 1'b0;
            if (beat == 0) begin
              first_addr = vif.vram_addr;
              first_data = vif.vram_din;
            end
          end
          check("beat_addr", vif.vram_addr, ref_addr(base, stride, tx, ty, beat));
          check("beat_data", vif.vram_din, ref_data(beat));
          if (beat == abort_at) begin
            reset_n    = 1'b0;
            pix_write  = 1'b0;
            flush      = 1'b0;
            clear_tile = 1'b0;
            aborted    = 1'b1;
            break;
          end
          w = 1'b0;
          if (wait_mode == 1) w = ($urandom_range(0, 3) == 0);
          else if (wait_mode == 2 && beat == 3 && stall_cnt < 5) begin
            w = 1'b1;
            stall_cnt++;
          end
          vif.vram_wait = w;
          if (w) stalls++;
          else begin
            beat++;
            new_beat = 1'b1;
          end
        end
      end else if (wait_mode == 1) begin
        vif.vram_wait = 1'($urandom_range(0, 1));
      end
      if (flush_done) begin
        done_k = k;
        break;
      end
    end
    if (aborted) begin
      @(negedge clock);
      reset_n = 1'b1;
      check("abort_vram_wr", vif.vram_wr, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_vram_addr", vif.vram_addr, 24'h000000);
      check("abort_vram_din", vif.vram_din, 32'h0000_0000);
      bad_done = 1'b0;
      bad_wr   = 1'b0;
      for (int k = 0; k < 1100; k++) begin
        @(negedge clock);
        if (flush_done) bad_done = 1'b1;
        if (vif.vram_wr || busy) bad_wr = 1'b1;
      end
      check("abort_no_flush_done", bad_done, 1'b0);
      check("abort_stays_idle", bad_wr, 1'b0);
    end else begin
      last_stalls = stalls;
      last_done   = done_k;
      check("beat_count", beat, 512);
      check("flush_done_cycle", done_k, 1026 + stalls);
      @(negedge clock);
      pix_write     = 1'b0;
      flush         = 1'b0;
      clear_tile    = 1'b0;
      vif.vram_wait = 1'b0;
      check("busy_after_flush", busy, 1'b0);
      check("vram_wr_after_flush", vif.vram_wr, 1'b0);
      if (with_clear) check("clear_dropped", seen_cd, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0012_3456, 32'h00FF_FFFF, 24'h001000, 12'd320,  6'd2,  5'd1,  0, 24'h003820, 32'hFFFF_11AA};
    vecs[1] = '{32'hFFFF_0000, 32'h0000_FF00, 24'h000000, 12'd320,  6'd0,  5'd0,  1, 24'h000000, 32'h07E0_F800};
    vecs[2] = '{32'h0000_00FF, 32'hAB80_8080, 24'hFFFFF0, 12'd16,   6'd0,  5'd0,  0, 24'hFFFFF0, 32'h8410_001F};
    vecs[3] = '{32'h0000_0000, 32'h0008_0400, 24'h123456, 12'd4095, 6'd63, 5'd31, 1, 24'h503466, 32'h0820_0000};

    reset_n = 1'b0; pix_write = 1'b0; pix_addr = 10'd0; pix_argb = 32'h0;
    clear_tile = 1'b0; bg_argb = 32'h0; flush = 1'b0; tile_x = 6'd0; tile_y = 5'd0;
    fb_base = 24'h0; fb_stride = 12'd0; vif.vram_wait = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy", busy, 1'b0);
    check("reset_clear_done", clear_done, 1'b0);
    check("reset_flush_done", flush_done, 1'b0);
    check("reset_vram_wr", vif.vram_wr, 1'b0);
    check("reset_vram_addr", vif.vram_addr, 24'h000000);
    check("reset_vram_din", vif.vram_din, 32'h0000_0000);
    reset_n = 1'b1;
    @(negedge clock);

    // Background clear to red, then stream it out with no wait states.
    run_clear(32'hFFFF_0000);
    run_flush(24'h000000, 12'd320, 6'd0, 5'd0, 0, 1'b0, 1'b0, -1);
    check("red_first_data", first_data, 32'hF800_F800);

    // Random tile contents, then table-driven packing/addressing vectors.
    for (int i = 0; i < 1024; i++) write_pix(i, $urandom);
    for (int v = 0; v < 4; v++) begin
      write_pix(0, vecs[v].pix0);
      write_pix(1, vecs[v].pix1);
      run_flush(vecs[v].base, vecs[v].stride, vecs[v].tx, vecs[v].ty,
                vecs[v].wait_mode, 1'b0, 1'b0, -1);
      check("vec_first_addr", first_addr, vecs[v].exp_addr);
      check("vec_first_data", first_data, vecs[v].exp_data);
    end

    // Five-cycle stall on beat 3.
    run_flush(24'h000200, 12'd100, 6'd5, 5'd3, 2, 1'b0, 1'b0, -1);
    check("stall_cycles", last_stalls, 5);
    check("stall_done_delay", last_done - 1026, 5);

    // Flush + clear together; traffic while busy must not disturb anything.
    run_flush(24'h000040, 12'd64, 6'd1, 5'd0, 1, 1'b1, 1'b1, -1);
    run_flush(24'h000040, 12'd64, 6'd1, 5'd0, 0, 1'b0, 1'b0, -1);

    // Reset at word 200, then a clean restart from word 0.
    run_flush(24'h000800, 12'd320, 6'd3, 5'd2, 0, 1'b0, 1'b0, 200);
    run_flush(24'h000800, 12'd320, 6'd3, 5'd2, 0, 1'b0, 1'b0, -1);

    // Randomized rounds.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) write_pix(int'($urandom_range(0, 1023)), $urandom);
      run_flush(24'($urandom), 12'($urandom), 6'($urandom), 5'($urandom), 1, 1'b0, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
